// File: rtl/usb_dev_pkg.sv
// usb_dev_pkg: shared PIDs, FSM states, packet struct and defaults for the USB device responder
package usb_dev_pkg;
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_e;
  typedef struct packed {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
  } pkt_t;
  localparam logic [6:0] DEF_DEV_ADDR = 7'd5;
  localparam logic [3:0] DEF_ADDR_EP = 4'd4;
  localparam logic [3:0] DEF_DATA_EP = 4'd8;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_OUT_DATA  = 3'd1;
  localparam logic [2:0] S_MEM_WRITE = 3'd2;
  localparam logic [2:0] S_SEND_HS   = 3'd3;
  localparam logic [2:0] S_IN_FETCH  = 3'd4;
  localparam logic [2:0] S_SEND_DATA = 3'd5;
  localparam logic [2:0] S_IN_HS     = 3'd6;
  localparam int F_GARBLE  = 0;
  localparam int F_TIMEOUT = 1;
  localparam int F_NAK     = 2;
endpackage

// File: rtl/usb_dev_fault_arm.sv
// usb_dev_fault_arm: sticky one-shot fault arms, set by pulses and cleared when consumed
module usb_dev_fault_arm (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] set,
  input  logic [2:0] clr,
  output logic [2:0] arm
);
  // a pulse landing on the consuming cycle re-arms for the next event
  always_ff @(posedge clk)
    arm <= rst ? '0 : (arm & ~clr) | set;
endmodule

// File: rtl/usb_dev_responder.sv
// usb_dev_responder: device-side OUT/IN transaction responder driving a flash port
module usb_dev_responder
  import usb_dev_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter logic [3:0] ADDR_EP     = DEF_ADDR_EP,
  parameter logic [3:0] DATA_EP     = DEF_DATA_EP,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [6:0]  rx_addr,
  input  logic [3:0]  rx_endp,
  input  logic [63:0] rx_data,
  input  logic        rx_crc_ok,
  output logic        tx_valid,
  output logic [3:0]  tx_pid,
  output logic [63:0] tx_data,
  output logic        tx_corrupt,
  input  logic        tx_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        inj_garble,
  input  logic        inj_timeout,
  input  logic        inj_nak
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic ep_is_data;
  logic [2:0] arm, arm_set, arm_clr;
  pkt_t rx;
  logic tok_ok, hit_out, hit_in, timed_out;
  assign rx = '{pid: rx_pid, addr: rx_addr, endp: rx_endp, data: rx_data};
  assign tok_ok = rx_valid && rx_crc_ok && rx.addr == DEV_ADDR;
  assign hit_out = tok_ok && rx.pid == PID_OUT && (rx.endp == ADDR_EP || rx.endp == DATA_EP);
  assign hit_in = tok_ok && rx.pid == PID_IN && rx.endp == DATA_EP;
  assign timed_out = cnt == CW'(TIMEOUT_CYC - 1);
  assign arm_set = {inj_nak, inj_timeout, inj_garble};
  // nak takes priority over timeout; garble is spent only once its packet is accepted
  assign arm_clr = {state == S_IDLE && hit_in,
                    state == S_IDLE && hit_in && !arm[F_NAK],
                    tx_valid && tx_ready && tx_corrupt};
  usb_dev_fault_arm u_arm (
    .clk(clk),
    .rst(rst),
    .set(arm_set),
    .clr(arm_clr),
    .arm(arm)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      ep_is_data <= 1'b0;
      tx_valid <= 1'b0;
      tx_pid <= '0;
      tx_data <= '0;
      tx_corrupt <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        S_IDLE:
          if (hit_out) begin
            state <= S_OUT_DATA;
            cnt <= '0;
            ep_is_data <= rx.endp == DATA_EP;
          end else if (hit_in) begin
            if (arm[F_NAK]) begin
              state <= S_SEND_HS;
              tx_valid <= 1'b1;
              tx_pid <= PID_NAK;
              tx_data <= '0;
              tx_corrupt <= arm[F_GARBLE];
            end else if (!arm[F_TIMEOUT]) begin
              state <= S_IN_FETCH;
              mem_rd <= 1'b1;
            end
          end
        S_OUT_DATA:
          if (rx_valid) begin
            if (rx.pid != PID_DATA0) begin
              state <= S_IDLE;
            end else if (!rx_crc_ok || !ep_is_data) begin
              state <= S_SEND_HS;
              tx_valid <= 1'b1;
              tx_pid <= rx_crc_ok ? PID_ACK : PID_NAK;
              tx_data <= '0;
              tx_corrupt <= arm[F_GARBLE];
              mem_addr <= rx_crc_ok ? rx.data[15:0] : mem_addr;
            end else begin
              state <= S_MEM_WRITE;
              mem_wr <= 1'b1;
              mem_wdata <= rx.data;
            end
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        S_MEM_WRITE:
          if (mem_ack) begin
            state <= S_SEND_HS;
            tx_valid <= 1'b1;
            tx_pid <= PID_ACK;
            tx_data <= '0;
            tx_corrupt <= arm[F_GARBLE];
          end
        S_IN_FETCH:
          if (mem_ack) begin
            state <= S_SEND_DATA;
            tx_valid <= 1'b1;
            tx_pid <= PID_DATA0;
            tx_data <= mem_rdata;
            tx_corrupt <= arm[F_GARBLE];
          end
        S_SEND_HS, S_SEND_DATA:
          if (tx_ready) begin
            state <= state == S_SEND_DATA ? S_IN_HS : S_IDLE;
            tx_valid <= 1'b0;
            tx_corrupt <= 1'b0;
            cnt <= '0;
          end
        S_IN_HS:
          if ((rx_valid && (rx.pid == PID_ACK || rx.pid == PID_NAK)) || timed_out)
            state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_dev_responder.sv
// tb_usb_dev_responder: randomized transaction bench with a flash model and a protocol-level reference
module tb_usb_dev_responder;
  localparam logic [6:0] DEV = 7'd5;
  localparam logic [3:0] EP_A = 4'd4, EP_D = 4'd8;
  localparam int TO = 255;
  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_D0 = 4'b0011, P_ACK = 4'b0010, P_NAK = 4'b1010;
  logic clk = 0, rst = 1;
  logic rx_valid = 0, rx_crc_ok = 0;
  logic [3:0] rx_pid = 0, rx_endp = 0;
  logic [6:0] rx_addr = 0;
  logic [63:0] rx_data = 0;
  logic tx_valid, tx_corrupt;
  logic [3:0] tx_pid;
  logic [63:0] tx_data;
  logic tx_ready = 0;
  logic mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 0;
  logic mem_ack = 0;
  logic inj_garble = 0, inj_timeout = 0, inj_nak = 0;
  int checks = 0, passes = 0;
  usb_dev_responder dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
    .rx_data(rx_data), .rx_crc_ok(rx_crc_ok),
    .tx_valid(tx_valid), .tx_pid(tx_pid), .tx_data(tx_data), .tx_corrupt(tx_corrupt),
    .tx_ready(tx_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .inj_garble(inj_garble), .inj_timeout(inj_timeout), .inj_nak(inj_nak)
  );
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  // flash model with random 0..2 cycle ack latency
  logic [63:0] flash [logic [15:0]];
  int n_wr = 0, n_rd = 0;
  logic [15:0] last_wr_addr = 0;
  logic [63:0] last_wr_data = 0;
  bit mem_hold = 0;
  initial forever begin
    @(negedge clk);
    if ((mem_wr || mem_rd) && !rst) begin
      if (mem_wr) begin
        n_wr++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
        flash[mem_addr] = mem_wdata;
      end else n_rd++;
      if (!mem_hold) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        mem_rdata = flash.exists(mem_addr) ? flash[mem_addr] : 64'h0;
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        mem_rdata = {$urandom, $urandom};
      end
    end
  end
  // reference model: what the host should observe
  logic [63:0] ref_mem [logic [15:0]];
  logic [15:0] ref_addr = 0;
  bit m_garble = 0, m_timeout = 0, m_nak = 0;
  function automatic logic [63:0] ref_read();
    return ref_mem.exists(ref_addr) ? ref_mem[ref_addr] : 64'h0;
  endfunction
  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] ep,
                          input logic [63:0] d, input bit ok);
    rx_pid = pid; rx_addr = a; rx_endp = ep; rx_data = d; rx_crc_ok = ok; rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic inject(input int k);
    inj_garble = k == 0; inj_timeout = k == 1; inj_nak = k == 2;
    @(negedge clk);
    inj_garble = 0; inj_timeout = 0; inj_nak = 0;
    if (k == 0) m_garble = 1;
    if (k == 1) m_timeout = 1;
    if (k == 2) m_nak = 1;
  endtask
  task automatic get_tx(input int budget, output bit got, output logic [3:0] pid,
                        output logic [63:0] data, output logic cor, output bit stable);
    int n = 0;
    got = 0; stable = 1; pid = 0; data = 0; cor = 0;
    while (!tx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_valid) begin
      got = 1; pid = tx_pid; data = tx_data; cor = tx_corrupt;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        if (tx_valid !== 1'b1 || tx_pid !== pid || tx_data !== data || tx_corrupt !== cor) stable = 0;
      end
      tx_ready = 1;
      @(negedge clk);
      tx_ready = 0;
      if (tx_valid !== 1'b0) stable = 0;
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, tx_pid, tx_data, tx_corrupt, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_outputs: got tx_valid=%b tx_pid=%h mem_addr=%h, want all 0", tx_valid, tx_pid, mem_addr);
    else passes++;
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid, mem_rd, mem_wr} !== 3'b000) $display("FAIL idle_after_reset: got %b want 000", {tx_valid, mem_rd, mem_wr});
    else passes++;
  endtask
  task automatic test_addr_write(input logic [15:0] a);
    bit got, st; logic [3:0] p; logic [63:0] d; logic c; int wr0 = n_wr; logic [63:0] pl;
    pl = {$urandom, $urandom};
    pl[15:0] = a;
    send_pkt(P_OUT, DEV, EP_A, 64'h0, 1);
    send_pkt(P_D0, 7'd0, 4'd0, pl, 1);
    get_tx(12, got, p, d, c, st);
    checks++;
    if ({got, p} !== {1'b1, P_ACK}) $display("FAIL addr_ack: got valid=%b pid=%h want 1/%h", got, p, P_ACK); else passes++;
    checks++;
    if (c !== m_garble) $display("FAIL addr_corrupt: got %b want %b", c, m_garble); else passes++;
    checks++;
    if (!st) $display("FAIL addr_hs_stable: got unstable want stable"); else passes++;
    checks++;
    if (mem_addr !== a) $display("FAIL addr_reg: got %h want %h", mem_addr, a); else passes++;
    checks++;
    if (n_wr !== wr0) $display("FAIL addr_no_write: got %0d writes want %0d", n_wr, wr0); else passes++;
    ref_addr = a;
    m_garble = 0;
  endtask
  task automatic test_data_write(input logic [63:0] v, input bit ok);
    bit got, st; logic [3:0] p; logic [63:0] d; logic c; int wr0 = n_wr;
    send_pkt(P_OUT, DEV, EP_D, 64'h0, 1);
    send_pkt(P_D0, 7'd0, 4'd0, v, ok);
    get_tx(12, got, p, d, c, st);
    checks++;
    if ({got, p} !== {1'b1, ok ? P_ACK : P_NAK})
      $display("FAIL wr_hs: got valid=%b pid=%h want 1/%h", got, p, ok ? P_ACK : P_NAK);
    else passes++;
    checks++;
    if (c !== m_garble) $display("FAIL wr_corrupt: got %b want %b", c, m_garble); else passes++;
    checks++;
    if (!st) $display("FAIL wr_hs_stable: got unstable want stable"); else passes++;
    checks++;
    if (n_wr !== wr0 + (ok ? 1 : 0)) $display("FAIL wr_count: got %0d want %0d", n_wr, wr0 + (ok ? 1 : 0)); else passes++;
    if (ok) begin
      checks++;
      if ({last_wr_addr, last_wr_data} !== {ref_addr, v})
        $display("FAIL wr_content: got %h/%h want %h/%h", last_wr_addr, last_wr_data, ref_addr, v);
      else passes++;
      ref_mem[ref_addr] = v;
    end
    m_garble = 0;
  endtask
  task automatic test_read;
    bit got, st; logic [3:0] p; logic [63:0] d; logic c;
    bit exp_nak = m_nak, exp_none = !m_nak && m_timeout;
    logic [63:0] exp_d = ref_read();
    int rd0 = n_rd;
    send_pkt(P_IN, DEV, EP_D, {32'h0, $urandom}, 1);
    get_tx(exp_none ? TO : 12, got, p, d, c, st);
    checks++;
    if (got !== !exp_none) $display("FAIL rd_response: got %b want %b", got, !exp_none); else passes++;
    if (!exp_none) begin
      checks++;
      if (p !== (exp_nak ? P_NAK : P_D0)) $display("FAIL rd_pid: got %h want %h", p, exp_nak ? P_NAK : P_D0); else passes++;
      checks++;
      if (c !== m_garble) $display("FAIL rd_corrupt: got %b want %b", c, m_garble); else passes++;
      checks++;
      if (!st) $display("FAIL rd_stable: got unstable want stable"); else passes++;
      if (!exp_nak) begin
        checks++;
        if (d !== exp_d) $display("FAIL rd_data: got %h want %h", d, exp_d); else passes++;
      end
    end
    checks++;
    if (n_rd !== rd0 + (exp_nak || exp_none ? 0 : 1))
      $display("FAIL rd_mem_reads: got %0d want %0d", n_rd, rd0 + (exp_nak || exp_none ? 0 : 1));
    else passes++;
    if (exp_nak) m_nak = 0;
    else if (exp_none) m_timeout = 0;
    if (!exp_none) m_garble = 0;
    if (!exp_nak && !exp_none) send_pkt(c ? P_NAK : P_ACK, 7'd0, 4'd0, 64'h0, 1);
  endtask
  task automatic test_write_read;
    test_addr_write(16'h00AB);
    test_data_write(64'hCAFEBABEDEADBEEF, 1);
    test_read;
    test_read;
  endtask
  task automatic test_garble;
    inject(0);
    inject(0);
    test_read;
    test_read;
    inject(0);
    test_addr_write(16'h00AB);
    test_read;
  endtask
  task automatic test_timeout;
    inject(1);
    test_read;
    test_read;
  endtask
  task automatic test_nak;
    inject(2);
    test_read;
    test_read;
    test_data_write({$urandom, $urandom}, 0);
    test_read;
  endtask
  task automatic test_ignored;
    bit got, st; logic [3:0] p; logic [63:0] d; logic c; int rd0 = n_rd, wr0 = n_wr;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: send_pkt(P_IN, 7'd6, EP_D, 64'h0, 1);
        1: begin send_pkt(P_OUT, 7'd6, EP_A, 64'h0, 1); send_pkt(P_D0, 7'd0, 4'd0, 64'h1234, 1); end
        2: send_pkt(P_IN, DEV, EP_D, 64'h0, 0);
        3: send_pkt(P_IN, DEV, 4'd3, 64'h0, 1);
        default: begin send_pkt(P_OUT, DEV, 4'd3, 64'h0, 1); send_pkt(P_D0, 7'd0, 4'd0, 64'h5678, 1); end
      endcase
      get_tx(15, got, p, d, c, st);
      checks++;
      if (got !== 1'b0) $display("FAIL ignored_%0d: got response pid=%h want none", i, p); else passes++;
    end
    checks++;
    if ({n_rd, n_wr} !== {rd0, wr0}) $display("FAIL ignored_mem: got rd=%0d wr=%0d want %0d/%0d", n_rd, n_wr, rd0, wr0); else passes++;
    checks++;
    if (mem_addr !== ref_addr) $display("FAIL ignored_addr: got %h want %h", mem_addr, ref_addr); else passes++;
  endtask
  task automatic test_drop;
    bit got, st; logic [3:0] p; logic [63:0] d; logic c; int n = 0, rd0 = n_rd;
    send_pkt(P_IN, DEV, EP_D, 64'h0, 1);
    while (!tx_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    send_pkt(P_IN, DEV, EP_D, 64'h0, 1);
    checks++;
    if ({tx_valid, tx_pid, tx_corrupt} !== {1'b1, P_D0, m_garble})
      $display("FAIL drop_pending: got %b/%h/%b want 1/%h/%b", tx_valid, tx_pid, tx_corrupt, P_D0, m_garble);
    else passes++;
    checks++;
    if (tx_data !== ref_read()) $display("FAIL drop_data: got %h want %h", tx_data, ref_read()); else passes++;
    tx_ready = 1;
    @(negedge clk);
    tx_ready = 0;
    send_pkt(P_ACK, 7'd0, 4'd0, 64'h0, 1);
    get_tx(10, got, p, d, c, st);
    checks++;
    if (got !== 1'b0) $display("FAIL drop_extra: got response pid=%h want none", p); else passes++;
    checks++;
    if (n_rd !== rd0 + 1) $display("FAIL drop_reads: got %0d want %0d", n_rd, rd0 + 1); else passes++;
  endtask
  task automatic test_random;
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = 16'($urandom_range(0, 3)) * 16'h1111; test_addr_write(a); end
        1, 2: test_data_write({$urandom, $urandom}, $urandom_range(0, 3) != 0);
        3, 4: test_read;
        default: inject(int'($urandom_range(0, 2)));
      endcase
    end
  endtask
  task automatic test_reset_mid;
    bit got, st; logic [3:0] p; logic [63:0] d; logic c; int rd0;
    while (m_nak || m_timeout) test_read;
    mem_hold = 1;
    rd0 = n_rd;
    send_pkt(P_IN, DEV, EP_D, 64'h0, 1);
    repeat (2) @(negedge clk);
    checks++;
    if ({n_rd, tx_valid} !== {rd0 + 1, 1'b0}) $display("FAIL fetch_started: got rd=%0d tx_valid=%b want %0d/0", n_rd, tx_valid, rd0 + 1); else passes++;
    inject(2);
    inject(0);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    mem_hold = 0;
    ref_addr = 0; m_nak = 0; m_garble = 0; m_timeout = 0;
    checks++;
    if ({tx_valid, tx_pid, tx_data, tx_corrupt, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_mid_outputs: got tx_valid=%b mem_addr=%h want all 0", tx_valid, mem_addr);
    else passes++;
    get_tx(8, got, p, d, c, st);
    checks++;
    if (got !== 1'b0) $display("FAIL reset_mid_silent: got response pid=%h want none", p); else passes++;
    test_read;
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_garble;
    test_timeout;
    test_nak;
    test_ignored;
    test_drop;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
